// File: rtl/ball_motion_ctrl_pkg.sv
// Shared definitions for the ball motion sequencer: FSM encoding, default
// screen geometry and the constant log2 helper used to size position ports.
package ball_motion_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH  = 1024;
  localparam int unsigned DEF_HEIGHT = 768;
  localparam int unsigned DEF_RADIUS = 16;

  // Ceiling log2: the number of bits needed to index 'value' items.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned v;
    int unsigned n;
    n = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      n = n + 1;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_axis_step.sv
// Combinational per-axis step: advances a position by a fixed step in the
// current direction and clamps/reflects it at the radius-inset screen edges.
module ball_axis_step
  import ball_motion_ctrl_pkg::*;
#(
  parameter int unsigned extent = DEF_WIDTH,
  parameter int unsigned radius = DEF_RADIUS,
  parameter int unsigned step   = 2,
  parameter int unsigned pos_w  = log2(extent)
) (
  input  logic [pos_w-1:0] pos,
  input  logic             dir,
  output logic [pos_w-1:0] next_pos,
  output logic             next_dir,
  output logic             reflect
);

  localparam logic [pos_w:0]   lo_w   = (pos_w+1)'(radius);
  localparam logic [pos_w:0]   hi_w   = (pos_w+1)'(extent - 1 - radius);
  localparam logic [pos_w:0]   step_w = (pos_w+1)'(step);
  localparam logic [pos_w-1:0] lo_n   = pos_w'(radius);
  localparam logic [pos_w-1:0] hi_n   = pos_w'(extent - 1 - radius);
  localparam logic [pos_w-1:0] step_n = pos_w'(step);

  logic [pos_w:0] sum;

  // Next position with one extra bit so overshoot past the upper limit is visible.
  always_comb begin
    sum      = {1'b0, pos} + step_w;
    next_pos = pos;
    next_dir = dir;
    reflect  = 1'b0;
    if (dir) begin
      if (sum > hi_w) begin
        next_pos = hi_n;
        next_dir = 1'b0;
        reflect  = 1'b1;
      end else begin
        next_pos = sum[pos_w-1:0];
      end
    end else begin
      if ({1'b0, pos} < lo_w + step_w) begin
        next_pos = lo_n;
        next_dir = 1'b1;
        reflect  = 1'b1;
      end else begin
        next_pos = pos - step_n;
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position sequencer: on every frame_div-th accepted frame strobe it
// steps X, then Y, then commits both positions, directions and the bounce
// pulse in a single cycle so the renderer never sees a half-updated ball.
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter int unsigned width       = DEF_WIDTH,
  parameter int unsigned height      = DEF_HEIGHT,
  parameter int unsigned ball_radius = DEF_RADIUS,
  parameter int unsigned step        = 2,
  parameter int unsigned frame_div   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ball_en,
  input  logic                      move,
  input  logic                      pause,
  output logic [log2(width)-1:0]    h_pos,
  output logic [log2(height)-1:0]   v_pos,
  output logic                      dir_x,
  output logic                      dir_y,
  output logic [1:0]                bounce,
  output logic                      busy
);

  localparam int unsigned hw    = log2(width);
  localparam int unsigned vw    = log2(height);
  localparam int unsigned div_w = (frame_div > 1) ? log2(frame_div) : 1;
  localparam logic [div_w-1:0] div_last = div_w'(frame_div - 1);

  state_t           state, state_nx;
  logic [div_w-1:0] div_cnt;
  logic             accept, start;

  logic [hw-1:0] nx_c, nx_q;
  logic [vw-1:0] ny_c, ny_q;
  logic          ndx_c, ndx_q, bx_c, bx_q;
  logic          ndy_c, ndy_q, by_c, by_q;

  ball_axis_step #(
    .extent (width),
    .radius (ball_radius),
    .step   (step),
    .pos_w  (hw)
  ) u_step_x (
    .pos      (h_pos),
    .dir      (dir_x),
    .next_pos (nx_c),
    .next_dir (ndx_c),
    .reflect  (bx_c)
  );

  ball_axis_step #(
    .extent (height),
    .radius (ball_radius),
    .step   (step),
    .pos_w  (vw)
  ) u_step_y (
    .pos      (v_pos),
    .dir      (dir_y),
    .next_pos (ny_c),
    .next_dir (ndy_c),
    .reflect  (by_c)
  );

  // Strobe qualification and next-state decode.
  always_comb begin
    accept   = move && ball_en && !pause && (state == IDLE);
    start    = accept && (div_cnt == div_last);
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STEP_X;
      STEP_X:  state_nx = STEP_Y;
      STEP_Y:  state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and accepted-strobe divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      if (accept) begin
        div_cnt <= start ? '0 : div_cnt + div_w'(1);
      end
    end
  end

  // Stage per-axis results; publish them all together in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      nx_q   <= '0;
      ndx_q  <= 1'b0;
      bx_q   <= 1'b0;
      ny_q   <= '0;
      ndy_q  <= 1'b0;
      by_q   <= 1'b0;
      h_pos  <= hw'(width / 2);
      v_pos  <= vw'(height / 2);
      dir_x  <= 1'b1;
      dir_y  <= 1'b1;
      bounce <= '0;
    end else begin
      bounce <= '0;
      case (state)
        STEP_X: begin
          nx_q  <= nx_c;
          ndx_q <= ndx_c;
          bx_q  <= bx_c;
        end
        STEP_Y: begin
          ny_q  <= ny_c;
          ndy_q <= ndy_c;
          by_q  <= by_c;
        end
        COMMIT: begin
          h_pos  <= nx_q;
          v_pos  <= ny_q;
          dir_x  <= ndx_q;
          dir_y  <= ndy_q;
          bounce <= {by_q, bx_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: default geometry, a 64x64 screen and
// a divide-by-3 instance share one stimulus set.
module tb_ball_motion_ctrl;

  logic clk = 1'b0;
  logic reset, ball_en, move, pause;

  logic [9:0] h_a, v_a;
  logic       dx_a, dy_a, busy_a;
  logic [1:0] bn_a;

  logic [5:0] h_s, v_s;
  logic       dx_s, dy_s, busy_s;
  logic [1:0] bn_s;

  logic [9:0] h_d, v_d;
  logic       dx_d, dy_d, busy_d;
  logic [1:0] bn_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl u_dut (
    .clk(clk), .reset(reset), .ball_en(ball_en), .move(move), .pause(pause),
    .h_pos(h_a), .v_pos(v_a), .dir_x(dx_a), .dir_y(dy_a), .bounce(bn_a), .busy(busy_a)
  );

  ball_motion_ctrl #(.width(64), .height(64)) u_small (
    .clk(clk), .reset(reset), .ball_en(ball_en), .move(move), .pause(pause),
    .h_pos(h_s), .v_pos(v_s), .dir_x(dx_s), .dir_y(dy_s), .bounce(bn_s), .busy(busy_s)
  );

  ball_motion_ctrl #(.frame_div(3)) u_div (
    .clk(clk), .reset(reset), .ball_en(ball_en), .move(move), .pause(pause),
    .h_pos(h_d), .v_pos(v_d), .dir_x(dx_d), .dir_y(dy_d), .bounce(bn_d), .busy(busy_d)
  );

  typedef struct {
    logic       en;
    logic       pa;
    int         h;
    int         v;
    logic       dx;
    logic       dy;
    logic [1:0] bn;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One-cycle strobe; returns one cycle after the strobe cycle.
  task automatic pulse_move(input logic en, input logic pa);
    ball_en = en;
    pause   = pa;
    move    = 1'b1;
    tick();
    move    = 1'b0;
    ball_en = 1'b1;
    pause   = 1'b0;
  endtask

  // Strobe then wait until the commit is visible (t+4).
  task automatic do_update(input logic en, input logic pa);
    pulse_move(en, pa);
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; ball_en = 1'b1; move = 1'b0; pause = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 516, 388, 1'b1, 1'b1, 2'b00};
    tbl[1] = '{1'b0, 1'b0, 516, 388, 1'b1, 1'b1, 2'b00};
    tbl[2] = '{1'b1, 1'b1, 516, 388, 1'b1, 1'b1, 2'b00};
    tbl[3] = '{1'b1, 1'b0, 518, 390, 1'b1, 1'b1, 2'b00};

    // 1. Reset values, then reset during COMMIT discards the update.
    do_reset();
    check("rst_h", int'(h_a), 512);
    check("rst_v", int'(v_a), 384);
    check("rst_dx", int'(dx_a), 1);
    check("rst_dy", int'(dy_a), 1);
    check("rst_bounce", int'(bn_a), 0);
    check("rst_busy", int'(busy_a), 0);
    pulse_move(1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("commit_rst_h", int'(h_a), 512);
    check("commit_rst_v", int'(v_a), 384);
    check("commit_rst_bounce", int'(bn_a), 0);
    check("commit_rst_busy", int'(busy_a), 0);
    tick();
    check("commit_rst_h2", int'(h_a), 512);

    // 2. Single update timing; a strobe while busy is dropped.
    pulse_move(1'b1, 1'b0);
    check("busy_t1", int'(busy_a), 1);
    check("h_hold_t1", int'(h_a), 512);
    tick();
    check("busy_t2", int'(busy_a), 1);
    move = 1'b1;
    tick();
    move = 1'b0;
    check("busy_t3", int'(busy_a), 1);
    check("h_hold_t3", int'(h_a), 512);
    tick();
    check("upd_h", int'(h_a), 514);
    check("upd_v", int'(v_a), 386);
    check("upd_bounce", int'(bn_a), 0);
    check("upd_busy", int'(busy_a), 0);
    tick();
    check("dropped_busy", int'(busy_a), 0);
    check("dropped_h", int'(h_a), 514);

    // Table: enabled, disabled, paused strobes on the default instance.
    for (int i = 0; i < 4; i++) begin
      do_update(tbl[i].en, tbl[i].pa);
      check($sformatf("tbl%0d_h", i), int'(h_a), tbl[i].h);
      check($sformatf("tbl%0d_v", i), int'(v_a), tbl[i].v);
      check($sformatf("tbl%0d_dx", i), int'(dx_a), int'(tbl[i].dx));
      check($sformatf("tbl%0d_dy", i), int'(dy_a), int'(tbl[i].dy));
      check($sformatf("tbl%0d_bn", i), int'(bn_a), int'(tbl[i].bn));
      tick();
    end

    // 3. Right-edge reflection (3 updates done; 247 reaches h=1006).
    for (int i = 3; i < 247; i++) begin
      do_update(1'b1, 1'b0);
      tick();
    end
    check("pre_edge_h", int'(h_a), 1006);
    check("pre_edge_v", int'(v_a), 625);
    check("pre_edge_dx", int'(dx_a), 1);
    check("pre_edge_dy", int'(dy_a), 0);
    do_update(1'b1, 1'b0);
    check("edge_h", int'(h_a), 1007);
    check("edge_v", int'(v_a), 623);
    check("edge_dx", int'(dx_a), 0);
    check("edge_bounce", int'(bn_a), 1);
    tick();
    check("edge_bounce_end", int'(bn_a), 0);
    do_update(1'b1, 1'b0);
    check("after_edge_h", int'(h_a), 1005);
    check("after_edge_v", int'(v_a), 621);
    check("after_edge_bounce", int'(bn_a), 0);
    tick();

    // 6. ball_en dropping during STEP_Y does not cancel the update.
    pulse_move(1'b1, 1'b0);
    tick();
    ball_en = 1'b0;
    tick();
    tick();
    check("en_drop_h", int'(h_a), 1003);
    check("en_drop_v", int'(v_a), 619);
    ball_en = 1'b1;
    tick();

    // 4. 64x64 screen: corner hit reflects both axes at once.
    do_reset();
    check("small_rst_h", int'(h_s), 32);
    for (int i = 0; i < 8; i++) begin
      do_update(1'b1, 1'b0);
      if (i < 7) begin
        check($sformatf("small%0d_h", i), int'(h_s), 34 + 2 * i);
        check($sformatf("small%0d_v", i), int'(v_s), 34 + 2 * i);
        check($sformatf("small%0d_bn", i), int'(bn_s), 0);
      end else begin
        check("corner_h", int'(h_s), 47);
        check("corner_v", int'(v_s), 47);
        check("corner_bn", int'(bn_s), 3);
        check("corner_dx", int'(dx_s), 0);
        check("corner_dy", int'(dy_s), 0);
      end
      tick();
    end
    do_update(1'b1, 1'b0);
    check("small9_h", int'(h_s), 45);
    check("small9_v", int'(v_s), 45);
    check("small9_bn", int'(bn_s), 0);
    tick();

    // 5. frame_div=3: paused/disabled strobes do not advance the divider.
    do_reset();
    do_update(1'b1, 1'b0);
    check("div_a1_h", int'(h_d), 512);
    do_update(1'b1, 1'b1);
    check("div_pause_h", int'(h_d), 512);
    do_update(1'b0, 1'b0);
    check("div_en0_h", int'(h_d), 512);
    pulse_move(1'b1, 1'b0);
    check("div_a2_busy", int'(busy_d), 0);
    repeat (3) tick();
    check("div_a2_h", int'(h_d), 512);
    do_update(1'b1, 1'b0);
    check("div_a3_h", int'(h_d), 514);
    check("div_a3_v", int'(v_d), 386);
    tick();
    do_update(1'b1, 1'b0);
    do_update(1'b1, 1'b0);
    check("div_a5_h", int'(h_d), 514);
    do_update(1'b1, 1'b0);
    check("div_a6_h", int'(h_d), 516);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
